// File: rtl/player_collision.sv
`default_nettype none
// ============================================================================
// Module  : player_collision
// Purpose : Once per frame, predicts the player's next position and probes
//           the tile map at the leading-edge corners.  The result is a 4-bit
//           collision vector {top, right, bottom, left}.
// Rev     : 1.0  initial release
// ============================================================================
module player_collision #(
   parameter int X0       = 144,
   parameter int Y0       = 35,
   parameter int TILE_SH  = 5,
   parameter int MAP_COLS = 20,
   parameter int MAP_ROWS = 15,
   parameter int PLAYER_W = 32,
   parameter int PLAYER_H = 32,
   parameter int ADDR_W   = 9
) (
   input  logic              sim_clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       playerState,
   output logic [ADDR_W-1:0] tile_addr,
   output logic              tile_rd,
   input  logic              tile_solid,
   output logic [3:0]        playerCol,
   output logic              col_valid,
   output logic              busy
);

   // All position arithmetic is 12-bit signed so that left/up overshoot
   // past the screen origin stays negative and is caught by the bounds test.
   localparam logic signed [11:0] c_X0    = 12'(X0);
   localparam logic signed [11:0] c_Y0    = 12'(Y0);
   localparam logic signed [11:0] c_X_END = 12'(X0 + (MAP_COLS << TILE_SH));
   localparam logic signed [11:0] c_Y_END = 12'(Y0 + (MAP_ROWS << TILE_SH));
   localparam logic signed [11:0] c_W1    = 12'(PLAYER_W - 1);
   localparam logic signed [11:0] c_H1    = 12'(PLAYER_H - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_PROBE = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state, w_state_n;
   logic [1:0]          r_k;
   logic [9:0]          r_x, r_y;
   logic [4:0]          r_xs, r_ys;
   logic                r_xd, r_yd;
   logic signed [11:0]  r_hx, r_vy;
   logic                r_hit_h, r_hit_v;
   logic                r_pend, r_pend_v;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_col;

   logic signed [11:0]  w_x0, w_y0, w_nx, w_ny, w_px, w_py;
   logic [11:0]         w_dx, w_dy, w_col, w_row;
   logic [ADDR_W-1:0]   w_lin;
   logic                w_inb, w_probing;
   logic                w_hit_h_n, w_hit_v_n;
   logic [3:0]          w_col_n;

   assign w_x0 = $signed({2'b00, r_x});
   assign w_y0 = $signed({2'b00, r_y});
   assign w_nx = r_xd ? w_x0 + $signed({7'b0, r_xs}) : w_x0 - $signed({7'b0, r_xs});
   assign w_ny = r_yd ? w_y0 - $signed({7'b0, r_ys}) : w_y0 + $signed({7'b0, r_ys});

   // Select the probe point for the current corner: k0/k1 horizontal, k2/k3 vertical
   always_comb begin
      w_px = r_hx;
      w_py = w_y0;
      case (r_k)
         2'd0: begin w_px = r_hx;        w_py = w_y0;        end
         2'd1: begin w_px = r_hx;        w_py = w_y0 + c_H1; end
         2'd2: begin w_px = w_x0;        w_py = r_vy;        end
         default: begin w_px = w_x0 + c_W1; w_py = r_vy;     end
      endcase
   end

   assign w_inb = (w_px >= c_X0) && (w_px < c_X_END) && (w_py >= c_Y0) && (w_py < c_Y_END);
   assign w_dx  = w_px - c_X0;
   assign w_dy  = w_py - c_Y0;
   assign w_col = w_dx >> TILE_SH;
   assign w_row = w_dy >> TILE_SH;
   assign w_lin = ADDR_W'(w_row) * ADDR_W'(MAP_COLS) + ADDR_W'(w_col);

   // Hits fold in both the returned read of the previous probe and an
   // off-map probe this cycle, which counts solid without a read.
   assign w_probing = (r_state == S_PROBE);
   assign w_hit_h_n = r_hit_h | (r_pend & ~r_pend_v & tile_solid) | (w_probing & ~w_inb & ~r_k[1]);
   assign w_hit_v_n = r_hit_v | (r_pend &  r_pend_v & tile_solid) | (w_probing & ~w_inb &  r_k[1]);

   // Map axis hits to direction bits; a stationary axis cannot collide,
   // except downward where zero speed still reports ground contact.
   always_comb begin
      w_col_n    = 4'b0000;
      w_col_n[0] = w_hit_h_n & ~r_xd & (r_xs != 5'd0);
      w_col_n[2] = w_hit_h_n &  r_xd & (r_xs != 5'd0);
      w_col_n[1] = w_hit_v_n & ~r_yd;
      w_col_n[3] = w_hit_v_n &  r_yd & (r_ys != 5'd0);
   end

   // State register
   always_ff @(posedge sim_clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_n;
   end

   // Next-state decode and control outputs
   always_comb begin
      w_state_n = r_state;
      col_valid = 1'b0;
      busy      = 1'b1;
      tile_rd   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_n = S_CALC;
         end
         S_CALC:  w_state_n = S_PROBE;
         S_PROBE: begin
            tile_rd = w_inb;
            if (r_k == 2'd3) w_state_n = S_DRAIN;
         end
         S_DRAIN: w_state_n = S_DONE;
         S_DONE: begin
            col_valid = 1'b1;
            w_state_n = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Off-map probes leave the address bus at the last real read
   assign tile_addr = tile_rd ? w_lin : r_addr;
   assign playerCol = r_col;

   // Datapath: latch state, form leading edges, walk corners, accumulate hits
   always_ff @(posedge sim_clk) begin
      if (!reset) begin
         r_k      <= 2'd0;
         r_x      <= 10'd0;
         r_y      <= 10'd0;
         r_xs     <= 5'd0;
         r_ys     <= 5'd0;
         r_xd     <= 1'b0;
         r_yd     <= 1'b0;
         r_hx     <= 12'sd0;
         r_vy     <= 12'sd0;
         r_hit_h  <= 1'b0;
         r_hit_v  <= 1'b0;
         r_pend   <= 1'b0;
         r_pend_v <= 1'b0;
         r_addr   <= '0;
         r_col    <= 4'b0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x  <= playerState[31:22];
                  r_y  <= playerState[21:12];
                  r_xs <= playerState[11:7];
                  r_ys <= playerState[6:2];
                  r_xd <= playerState[1];
                  r_yd <= playerState[0];
               end
            end
            S_CALC: begin
               r_hx    <= r_xd ? w_nx + c_W1 : w_nx;
               r_vy    <= r_yd ? w_ny : w_ny + c_H1;
               r_k     <= 2'd0;
               r_hit_h <= 1'b0;
               r_hit_v <= 1'b0;
               r_pend  <= 1'b0;
            end
            S_PROBE: begin
               r_k      <= r_k + 2'd1;
               r_hit_h  <= w_hit_h_n;
               r_hit_v  <= w_hit_v_n;
               r_pend   <= w_inb;
               r_pend_v <= r_k[1];
               if (w_inb) r_addr <= w_lin;
            end
            S_DRAIN: r_col <= w_col_n;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_player_collision.sv
`default_nettype none
// ============================================================================
// Module  : tb_player_collision
// Purpose : Self-checking bench for player_collision with a scoreboard of
//           expected collision vectors and a 1-cycle-latency tile map model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_player_collision;

   logic        sim_clk = 1'b0;
   logic        reset   = 1'b0;
   logic        start   = 1'b0;
   logic [31:0] playerState = 32'd0;
   logic [8:0]  tile_addr;
   logic        tile_rd;
   logic        tile_solid = 1'b0;
   logic [3:0]  playerCol;
   logic        col_valid;
   logic        busy;

   player_collision dut (
      .sim_clk     (sim_clk),
      .reset       (reset),
      .start       (start),
      .playerState (playerState),
      .tile_addr   (tile_addr),
      .tile_rd     (tile_rd),
      .tile_solid  (tile_solid),
      .playerCol   (playerCol),
      .col_valid   (col_valid),
      .busy        (busy)
   );

   always #5 sim_clk = ~sim_clk;

   typedef struct {
      logic [3:0] col;
      int         cyc;
   } exp_t;

   exp_t  sb[$];
   logic  map_q [0:299];
   int    cyc      = 0;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_valid  = 0;
   int    n_pushed = 0;
   logic        rd_hist   [0:12];
   logic [8:0]  addr_hist [0:12];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Tile map: read data appears the cycle after the strobe
   always @(posedge sim_clk)
      tile_solid <= (tile_rd && tile_addr < 9'd300) ? map_q[tile_addr] : 1'b0;

   always @(posedge sim_clk) cyc <= cyc + 1;

   function automatic int solid_at(input int px, input int py);
      if (px < 144 || px >= 144 + 640 || py < 35 || py >= 35 + 480) return 1;
      return map_q[((py - 35) / 32) * 20 + (px - 144) / 32] ? 1 : 0;
   endfunction

   function automatic logic [3:0] predict(input int x, input int y, input int xs,
                                          input int ys, input bit xd, input bit yd);
      int nx, ny, hx, vy, h, v;
      logic [3:0] r;
      nx = xd ? x + xs : x - xs;
      ny = yd ? y - ys : y + ys;
      hx = xd ? nx + 31 : nx;
      vy = yd ? ny : ny + 31;
      h  = solid_at(hx, y) | solid_at(hx, y + 31);
      v  = solid_at(x, vy) | solid_at(x + 31, vy);
      r  = 4'b0000;
      if (h != 0 && xs != 0) begin
         if (xd) r[2] = 1'b1; else r[0] = 1'b1;
      end
      if (v != 0) begin
         if (!yd) r[1] = 1'b1;
         else if (ys != 0) r[3] = 1'b1;
      end
      return r;
   endfunction

   // Scoreboard consumer: every col_valid pops one expectation
   always @(negedge sim_clk) begin
      if (reset && col_valid) begin
         n_valid++;
         if (sb.size() == 0) check("unexpected_col_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("playerCol", {28'd0, playerCol}, {28'd0, e.col});
            check("latency", cyc - e.cyc, 32'd7);
         end
      end
   end

   task automatic map_clear();
      for (int i = 0; i < 300; i++) map_q[i] = 1'b0;
   endtask

   // One evaluation; optional extra start pulses and an optional abort by reset
   task automatic run_eval(input int x, input int y, input int xs, input int ys,
                           input bit xd, input bit yd,
                           input int pulse_a, input int pulse_b, input int rst_at);
      @(negedge sim_clk);
      playerState = {x[9:0], y[9:0], xs[4:0], ys[4:0], xd, yd};
      start = 1'b1;
      if (rst_at < 0) begin
         sb.push_back('{col: predict(x, y, xs, ys, xd, yd), cyc: cyc});
         n_pushed++;
      end
      for (int off = 1; off <= 12; off++) begin
         @(negedge sim_clk);
         rd_hist[off]   = tile_rd;
         addr_hist[off] = tile_addr;
         if (off == 1) check("busy_calc", {31'd0, busy}, 32'd1);
         if (off == 8 && rst_at < 0) check("busy_after_done", {31'd0, busy}, 32'd0);
         if (rst_at >= 0 && off == rst_at + 1) begin
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_playerCol", {28'd0, playerCol}, 32'd0);
            check("abort_col_valid", {31'd0, col_valid}, 32'd0);
            reset = 1'b1;
         end
         start = (off == pulse_a || off == pulse_b);
         if (off == rst_at) reset = 1'b0;
      end
      start = 1'b0;
      check("sb_drained", sb.size(), 32'd0);
   endtask

   initial begin
      map_clear();
      repeat (3) @(negedge sim_clk);
      check("rst_playerCol", {28'd0, playerCol}, 32'd0);
      check("rst_col_valid", {31'd0, col_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tile_rd", {31'd0, tile_rd}, 32'd0);
      check("rst_tile_addr", {23'd0, tile_addr}, 32'd0);
      reset = 1'b1;

      // Empty map, moving right on open ground
      run_eval(200, 100, 4, 0, 1'b1, 1'b0, -1, -1, -1);
      check("empty_k3_addr", {23'd0, addr_hist[5]}, 32'd62);

      // Left overshoot past the playfield edge
      run_eval(146, 100, 4, 0, 1'b0, 1'b1, -1, -1, -1);
      check("oob_k0_rd", {31'd0, rd_hist[2]}, 32'd0);
      check("oob_k1_rd", {31'd0, rd_hist[3]}, 32'd0);
      check("oob_k0_addr_hold", {23'd0, addr_hist[2]}, 32'd62);
      check("oob_k2_rd", {31'd0, rd_hist[4]}, 32'd1);
      check("oob_k2_addr", {23'd0, addr_hist[4]}, 32'd40);
      check("oob_k3_addr", {23'd0, addr_hist[5]}, 32'd41);

      // Wall tile at col 3, row 2
      map_q[43] = 1'b1;
      run_eval(220, 99, 4, 0, 1'b1, 1'b1, -1, -1, -1);
      check("wall_k0_rd", {31'd0, rd_hist[2]}, 32'd1);
      check("wall_k0_addr", {23'd0, addr_hist[2]}, 32'd43);
      // Stationary against the same wall
      run_eval(220, 99, 0, 0, 1'b1, 1'b1, -1, -1, -1);

      // Solid floor row 14
      for (int i = 280; i < 300; i++) map_q[i] = 1'b1;
      run_eval(300, 450, 0, 5, 1'b1, 1'b0, -1, -1, -1);
      run_eval(300, 450, 0, 5, 1'b1, 1'b1, -1, -1, -1);
      run_eval(300, 452, 0, 0, 1'b1, 1'b0, -1, -1, -1);
      // Jumping through the top edge
      run_eval(300, 36, 0, 5, 1'b1, 1'b1, -1, -1, -1);

      // Extra start pulses mid-evaluation and in DONE must be ignored
      run_eval(300, 452, 0, 0, 1'b1, 1'b0, 3, 7, -1);
      check("held_playerCol", {28'd0, playerCol}, 32'd2);

      // Abort by reset during the probe phase
      run_eval(300, 450, 0, 5, 1'b1, 1'b0, -1, -1, 4);

      // Recovery after abort
      run_eval(300, 450, 0, 5, 1'b1, 1'b0, -1, -1, -1);

      repeat (4) @(negedge sim_clk);
      check("col_valid_count", n_valid, n_pushed);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
